// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Widest product the negate helper supports (WIDTH up to 128).
  localparam int unsigned MAX_PROD_W = 256;

  // Two's-complement negate when neg is set; callers zero-extend and keep the low bits.
  function automatic logic [MAX_PROD_W-1:0] cond_negate(
    input logic                  neg,
    input logic [MAX_PROD_W-1:0] value
  );
    return neg ? -value : value;
  endfunction

endpackage

// File: rtl/mult_acc_adder.sv
// Shared accumulator adder: WIDTH + WIDTH -> WIDTH+1, kept separate so the carry scheme can be swapped.
module mult_acc_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle through a single shared adder,
// signed operands handled by magnitude multiply plus final conditional negate.
module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     md,
  input  logic [WIDTH-1:0]     mr,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  import mult_pkg::*;

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mult_state_e       state_q, state_d;
  logic [WIDTH-1:0]  md_mag_q, md_mag_d;
  logic [WIDTH-1:0]  mr_q, mr_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PW-1:0]     product_q, product_d;

  logic              md_is_neg, mr_is_neg;
  logic [WIDTH-1:0]  md_abs, mr_abs;
  logic [WIDTH-1:0]  addend;
  logic [WIDTH:0]    step_sum;
  logic [PW-1:0]     final_acc;
  logic [MAX_PROD_W-1:0] negated_unused;
  logic [PW-1:0]     final_product;

  always_comb begin
    md_is_neg = signed_mode & md[WIDTH-1];
    mr_is_neg = signed_mode & mr[WIDTH-1];
    md_abs    = md_is_neg ? -md : md;
    mr_abs    = mr_is_neg ? -mr : mr;
    addend    = mr_q[0] ? md_mag_q : '0;
  end

  mult_acc_adder #(
    .WIDTH (WIDTH)
  ) u_acc_adder (
    .a   (acc_hi_q),
    .b   (addend),
    .sum (step_sum)
  );

  // acc_hi_q holds the post-shift upper half, whose top bit is always zero, so only
  // WIDTH bits are stored; the WIDTH+1-bit pre-shift value lives in step_sum.
  always_comb begin
    final_acc      = {step_sum, mr_q[WIDTH-1:1]};
    negated_unused = cond_negate(neg_q, {{(MAX_PROD_W - PW){1'b0}}, final_acc});
    final_product  = negated_unused[PW-1:0];
  end

  always_comb begin
    state_d   = state_q;
    md_mag_d  = md_mag_q;
    mr_d      = mr_q;
    acc_hi_d  = acc_hi_q;
    neg_d     = neg_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !abort) begin
          md_mag_d = md_abs;
          mr_d     = mr_abs;
          neg_d    = signed_mode & (md[WIDTH-1] ^ mr[WIDTH-1]);
          acc_hi_d = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          product_d = '0;
          count_d   = '0;
          state_d   = IDLE;
        end else begin
          acc_hi_d = step_sum[WIDTH:1];
          mr_d     = {step_sum[0], mr_q[WIDTH-1:1]};
          count_d  = count_q + CNT_W'(1);
          if (count_q == LAST_STEP) begin
            product_d = final_product;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          product_d = '0;
          state_d   = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      md_mag_q  <= '0;
      mr_q      <= '0;
      acc_hi_q  <= '0;
      neg_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      md_mag_q  <= md_mag_d;
      mr_q      <= mr_d;
      acc_hi_q  <= acc_hi_d;
      neg_q     <= neg_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    product   = product_q;
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised and directed checks of seq_multiplier at WIDTH=16 and an exhaustive WIDTH=4 sweep.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_in_valid, a_in_ready, a_signed, a_abort, a_out_valid, a_out_ready, a_busy;
  logic [15:0] a_md, a_mr;
  logic [31:0] a_product;

  logic        b_in_valid, b_in_ready, b_signed, b_abort, b_out_valid, b_out_ready, b_busy;
  logic [3:0]  b_md, b_mr;
  logic [7:0]  b_product;

  int n_checks = 0;
  int n_pass   = 0;

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .signed_mode(a_signed), .md(a_md), .mr(a_mr), .abort(a_abort),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .product(a_product), .busy(a_busy)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .signed_mode(b_signed), .md(b_md), .mr(b_mr), .abort(b_abort),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .product(b_product), .busy(b_busy)
  );

  // Reference: integer multiply of the operands interpreted per mode, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input int unsigned w, input logic [31:0] md,
                                          input logic [31:0] mr, input logic sm);
    longint a, b, p;
    logic [63:0] mask;
    a = longint'(md);
    b = longint'(mr);
    if (sm && md[w-1]) a = a - (longint'(1) << w);
    if (sm && mr[w-1]) b = b - (longint'(1) << w);
    p = a * b;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  task automatic op16(input logic [15:0] md, input logic [15:0] mr, input logic sm,
                      input logic hold, output logic [31:0] prod, output int lat,
                      output bit busy_ok);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!a_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a_md = md; a_mr = mr; a_signed = sm; a_in_valid = 1'b1; a_out_ready = !hold;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    a_md = 16'($urandom); a_mr = 16'($urandom); a_signed = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!a_out_valid && lat < 100) begin
      if (!a_busy) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!a_busy) busy_ok = 1'b0;
    prod = a_product;
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic op4(input logic [3:0] md, input logic [3:0] mr, input logic sm,
                     output logic [7:0] prod, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!b_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    b_md = md; b_mr = mr; b_signed = sm; b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    b_md = 4'($urandom); b_mr = 4'($urandom); b_signed = 1'($urandom);
    lat = 0;
    while (!b_out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    prod = b_product;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({a_in_ready, a_out_valid, a_busy} !== 3'b100)
      $display("FAIL reset_ctrl16: got rdy/vld/busy=%b expected 100", {a_in_ready, a_out_valid, a_busy});
    else n_pass++;
    n_checks++;
    if (a_product !== 32'h0) $display("FAIL reset_prod16: got %h expected 0", a_product);
    else n_pass++;
    n_checks++;
    if ({b_in_ready, b_out_valid, b_busy, b_product} !== {3'b100, 8'h00})
      $display("FAIL reset_dut4: got %b expected 10000000000", {b_in_ready, b_out_valid, b_busy, b_product});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] v_md [8] = '{16'hFFFF, 16'hFFFD, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h8000, 16'h8000};
    logic [15:0] v_mr [8] = '{16'hFFFF, 16'h0005, 16'h8000, 16'hFFFF, 16'hABCD, 16'hABCD, 16'h0002, 16'h0002};
    logic        v_sm [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] v_ex [8] = '{32'hFFFE0001, 32'hFFFFFFF1, 32'h40000000, 32'h00000001,
                              32'h0, 32'h0, 32'h00010000, 32'hFFFF0000};
    logic [31:0] prod;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 8; i++) begin
      op16(v_md[i], v_mr[i], v_sm[i], 1'b0, prod, lat, busy_ok);
      n_checks++;
      if (prod !== v_ex[i]) $display("FAIL dir_prod[%0d]: got %h expected %h", i, prod, v_ex[i]);
      else n_pass++;
      n_checks++;
      if (lat != 16) $display("FAIL dir_latency[%0d]: got %0d expected 16", i, lat);
      else n_pass++;
      n_checks++;
      if (!busy_ok) $display("FAIL dir_busy[%0d]: got busy low expected high", i);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [15:0] edge_vals [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] md, mr;
    logic sm;
    logic [63:0] r;
    logic [31:0] prod;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 60; i++) begin
      md = (($urandom & 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 16'($urandom);
      mr = (($urandom & 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 16'($urandom);
      sm = 1'($urandom);
      r = ref_mul(16, 32'(md), 32'(mr), sm);
      op16(md, mr, sm, 1'b0, prod, lat, busy_ok);
      n_checks++;
      if (prod !== r[31:0] || lat != 16)
        $display("FAIL rand[%0d] %h*%h sm=%b: got %h lat %0d expected %h lat 16", i, md, mr, sm, prod, lat, r[31:0]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] r;
    logic [31:0] prod;
    int lat;
    bit busy_ok;
    r = ref_mul(16, 32'h1234, 32'hF0F1, 1'b1);
    op16(16'h1234, 16'hF0F1, 1'b1, 1'b1, prod, lat, busy_ok);
    n_checks++;
    if (prod !== r[31:0]) $display("FAIL bp_prod: got %h expected %h", prod, r[31:0]);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = ((i % 2) == 0);
      a_md = 16'($urandom); a_mr = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({a_out_valid, a_in_ready} !== 2'b10 || a_product !== r[31:0])
        $display("FAIL bp_hold[%0d]: got vld/rdy=%b prod %h expected 10 prod %h",
                 i, {a_out_valid, a_in_ready}, a_product, r[31:0]);
      else n_pass++;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({a_in_ready, a_out_valid, a_busy} !== 3'b100)
      $display("FAIL bp_drain: got rdy/vld/busy=%b expected 100", {a_in_ready, a_out_valid, a_busy});
    else n_pass++;
    r = ref_mul(16, 32'h00FF, 32'h8001, 1'b0);
    op16(16'h00FF, 16'h8001, 1'b0, 1'b0, prod, lat, busy_ok);
    n_checks++;
    if (prod !== r[31:0] || lat != 16)
      $display("FAIL bp_next: got %h lat %0d expected %h lat 16", prod, lat, r[31:0]);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [63:0] r;
    logic [31:0] prod;
    int lat;
    bit busy_ok;
    bit seen;
    @(negedge clk);
    a_md = 16'h1357; a_mr = 16'h2468; a_signed = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    a_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_abort = 1'b0;
    n_checks++;
    if ({a_in_ready, a_out_valid, a_busy} !== 3'b100 || a_product !== 32'h0)
      $display("FAIL abort_calc: got rdy/vld/busy=%b prod %h expected 100 prod 0",
               {a_in_ready, a_out_valid, a_busy}, a_product);
    else n_pass++;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (a_out_valid || a_busy) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL abort_quiet: got out_valid/busy after abort expected none");
    else n_pass++;

    op16(16'h0123, 16'h0456, 1'b0, 1'b1, prod, lat, busy_ok);
    a_abort = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_abort = 1'b0;
    n_checks++;
    if ({a_in_ready, a_out_valid} !== 2'b10 || a_product !== 32'h0)
      $display("FAIL abort_done: got rdy/vld=%b prod %h expected 10 prod 0", {a_in_ready, a_out_valid}, a_product);
    else n_pass++;

    a_md = 16'h0003; a_mr = 16'h0003; a_in_valid = 1'b1; a_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    a_abort = 1'b0;
    n_checks++;
    if ({a_in_ready, a_busy} !== 2'b10)
      $display("FAIL abort_idle: got rdy/busy=%b expected 10", {a_in_ready, a_busy});
    else n_pass++;

    r = ref_mul(16, 32'hC001, 32'h7FFE, 1'b1);
    op16(16'hC001, 16'h7FFE, 1'b1, 1'b0, prod, lat, busy_ok);
    n_checks++;
    if (prod !== r[31:0] || lat != 16)
      $display("FAIL abort_next: got %h lat %0d expected %h lat 16", prod, lat, r[31:0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] r;
    logic [31:0] prod;
    int lat;
    bit busy_ok;
    op16(16'h0101, 16'h0202, 1'b0, 1'b0, prod, lat, busy_ok);
    @(negedge clk);
    a_md = 16'hBEEF; a_mr = 16'h1234; a_signed = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_in_ready, a_out_valid, a_busy} !== 3'b100 || a_product !== 32'h0)
      $display("FAIL reset_mid: got rdy/vld/busy=%b prod %h expected 100 prod 0",
               {a_in_ready, a_out_valid, a_busy}, a_product);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    r = ref_mul(16, 32'hBEEF, 32'h1234, 1'b1);
    op16(16'hBEEF, 16'h1234, 1'b1, 1'b0, prod, lat, busy_ok);
    n_checks++;
    if (prod !== r[31:0] || lat != 16)
      $display("FAIL reset_next: got %h lat %0d expected %h lat 16", prod, lat, r[31:0]);
    else n_pass++;
  endtask

  task automatic test_width4();
    logic [63:0] r;
    logic [7:0] prod;
    int lat;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          r = ref_mul(4, 32'(x), 32'(y), 1'(s));
          op4(4'(x), 4'(y), 1'(s), prod, lat);
          n_checks++;
          if (prod !== r[7:0] || lat != 4)
            $display("FAIL w4 %0d*%0d sm=%0d: got %h lat %0d expected %h lat 4", x, y, s, prod, lat, r[7:0]);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a_in_valid = 1'b0; a_signed = 1'b0; a_abort = 1'b0; a_out_ready = 1'b1; a_md = '0; a_mr = '0;
    b_in_valid = 1'b0; b_signed = 1'b0; b_abort = 1'b0; b_out_ready = 1'b1; b_md = '0; b_mr = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_width4();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
